rf_writeback_queue: RTL

//  Write-side front end of the 32x32 register file: buffers write-back requests from the

---
 rtl/rf_writeback_queue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
// In-order write-back queue in front of the 32x32 register file. Buffers
// write requests from the pipeline and drains one per cycle onto the
// registered rf_* write port. pend/fwd lookups let decode stall or forward.
//
// Build option: define RF_WBQ_FORWARD_EN to build the forwarding data mux.
// Without it fwd1_dat/fwd2_dat are tied to zero and only pend1/pend2 are valid.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_wsel,
  input  logic [31:0]   in_wdat,
  input  logic          drain_hold,
  output logic          rf_WEN,
  output logic [4:0]    rf_wsel,
  output logic [31:0]   rf_wdat,
  input  logic [4:0]    rsel1,
  input  logic [4:0]    rsel2,
  output logic          pend1,
  output logic          pend2,
  output logic [31:0]   fwd1_dat,
  output logic [31:0]   fwd2_dat,
  output logic [AW:0]   count
);

  logic [4:0]    wsel_q [DEPTH];
  logic [31:0]   wdat_q [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          rf_wen_q, rf_wen_d;
  logic [4:0]    rf_wsel_q, rf_wsel_d;
  logic [31:0]   rf_wdat_q, rf_wdat_d;

  logic          full;
  logic          alloc;
  logic          drain;
  logic          wr_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign in_ready = ~full;
  // r0 writes complete the handshake but never occupy an entry
  assign alloc    = in_valid & ~full & (in_wsel != 5'd0);
  assign drain    = (count_q != '0) & ~drain_hold;
  assign wr_en    = alloc & ~flush;

  assign rf_WEN   = rf_wen_q;
  assign rf_wsel  = rf_wsel_q;
  assign rf_wdat  = rf_wdat_q;
  assign count    = count_q;

  // Next-state for pointers, occupancy and the staged write port; flush wins
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rf_wen_d  = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_wdat_d = rf_wdat_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc) tail_d = tail_q + AW'(1);
      if (drain) begin
        rf_wen_d  = 1'b1;
        rf_wsel_d = wsel_q[head_q];
        rf_wdat_d = wdat_q[head_q];
        head_d    = head_q + AW'(1);
      end
      case ({alloc, drain})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and staged-output registers, cleared asynchronously
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= 5'd0;
      rf_wdat_q <= 32'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_wen_q  <= rf_wen_d;
      rf_wsel_q <= rf_wsel_d;
      rf_wdat_q <= rf_wdat_d;
    end
  end

  // Entry storage; contents are only read while the entry is valid, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      wsel_q[tail_q] <= in_wsel;
      wdat_q[tail_q] <= in_wdat;
    end
  end

`ifdef RF_WBQ_FORWARD_EN
  logic [31:0] dat1, dat2;
`endif
  logic          hit1, hit2;
  logic [AW-1:0] idx;

  // Pending lookup: scan oldest (staged) to youngest so the youngest match sticks
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef RF_WBQ_FORWARD_EN
    dat1 = 32'd0;
    dat2 = 32'd0;
`endif
    if (rf_wen_q) begin
      if (rf_wsel_q == rsel1) begin
        hit1 = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
        dat1 = rf_wdat_q;
`endif
      end
      if (rf_wsel_q == rsel2) begin
        hit2 = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
        dat2 = rf_wdat_q;
`endif
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (wsel_q[idx] == rsel1) begin
          hit1 = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
          dat1 = wdat_q[idx];
`endif
        end
        if (wsel_q[idx] == rsel2) begin
          hit2 = 1'b1;
`ifdef RF_WBQ_FORWARD_EN
          dat2 = wdat_q[idx];
`endif
        end
      end
    end
    if (rsel1 == 5'd0) begin
      hit1 = 1'b0;
`ifdef RF_WBQ_FORWARD_EN
      dat1 = 32'd0;
`endif
    end
    if (rsel2 == 5'd0) begin
      hit2 = 1'b0;
`ifdef RF_WBQ_FORWARD_EN
      dat2 = 32'd0;
`endif
    end
  end

  assign pend1 = hit1;
  assign pend2 = hit2;
`ifdef RF_WBQ_FORWARD_EN
  assign fwd1_dat = dat1;
  assign fwd2_dat = dat2;
`else
  assign fwd1_dat = 32'd0;
  assign fwd2_dat = 32'd0;
`endif

endmodule
